// File: rtl/lr_check_tagger_if.sv
// Pixel stream bundle: paired left/right disparities in, tagged disparity words out.
interface lr_check_tagger_if #(parameter int DWIDTH = 7);
   logic              din_valid;
   logic              sof;
   logic [DWIDTH-1:0] disp_l;
   logic [DWIDTH-1:0] disp_r;
   logic              dout_valid;
   logic [DWIDTH+1:0] dout;
   logic              dout_eol;

   modport master (output din_valid, sof, disp_l, disp_r,
                   input  dout_valid, dout, dout_eol);
   modport slave  (input  din_valid, sof, disp_l, disp_r,
                   output dout_valid, dout, dout_eol);
endinterface

// File: rtl/lr_check_tagger.sv
// Left-right consistency tagger: emits {mismatch, occlusion, dL} per left pixel; LRC_STATS_EN adds frame counters.
// Two enabled cycles from beat to dout; no backpressure, clken=0 freezes every register.
module lr_check_tagger #(
   parameter int DWIDTH = 7,
   parameter int WIDTH  = 640,
   parameter int CWIDTH = 10,
   parameter int TH     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clken,
   lr_check_tagger_if.slave  bus
`ifdef LRC_STATS_EN
   ,
   output logic [CWIDTH+9:0] occ_cnt,
   output logic [CWIDTH+9:0] mis_cnt,
   output logic              stats_valid
`endif
);
   localparam int                AW       = ((CWIDTH > DWIDTH) ? CWIDTH : DWIDTH) + 1;
   localparam logic [CWIDTH-1:0] LAST_COL = CWIDTH'(WIDTH - 1);
   localparam logic [DWIDTH:0]   TH_X     = (DWIDTH+1)'(TH);

   logic [DWIDTH-1:0]    row_buf [WIDTH];
   logic [DWIDTH-1:0]    rd_dat;
   logic [CWIDTH-1:0]    col, x;
   logic signed [AW-1:0] addr;
   logic                 beat, oob, eol;

   logic                 s1_vld, s1_oob, s1_eol, s1_fwd;
   logic [DWIDTH-1:0]    s1_dl, s1_dr;
   logic [DWIDTH-1:0]    dr;
   logic [DWIDTH:0]      dl_x, dr_x, diff;
   logic                 near, occ, mis;
   logic                 dout_valid_q, dout_eol_q;
   logic [DWIDTH+1:0]    dout_q;

   always_comb begin
      beat = clken & bus.din_valid;
      x    = bus.sof ? '0 : col;
      addr = $signed(AW'(x)) - $signed(AW'(bus.disp_l));
      oob  = addr[AW-1];
      eol  = (x == LAST_COL);
   end

   // Read-before-write on the same entry returns stale data; disp_l==0 takes s1_dr instead.
   always_ff @(posedge clk) begin
      if (beat) begin
         row_buf[x] <= bus.disp_r;
         if (!oob) begin
            rd_dat <= row_buf[addr[CWIDTH-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col          <= '0;
         s1_vld       <= 1'b0;
         s1_dl        <= '0;
         s1_dr        <= '0;
         s1_oob       <= 1'b0;
         s1_eol       <= 1'b0;
         s1_fwd       <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         dout_eol_q   <= 1'b0;
      end else if (clken) begin
         s1_vld <= bus.din_valid;
         if (bus.din_valid) begin
            col    <= eol ? '0 : x + CWIDTH'(1);
            s1_dl  <= bus.disp_l;
            s1_dr  <= bus.disp_r;
            s1_oob <= oob;
            s1_eol <= eol;
            s1_fwd <= (bus.disp_l == '0);
         end
         dout_valid_q <= s1_vld;
         if (s1_vld) begin
            dout_q     <= {mis, occ, s1_dl};
            dout_eol_q <= s1_eol;
         end
      end
   end

   // A right view seeing a nearer surface is an occlusion, anything else inconsistent is a mismatch.
   always_comb begin
      dr   = s1_fwd ? s1_dr : rd_dat;
      dl_x = {1'b0, s1_dl};
      dr_x = {1'b0, dr};
      diff = (dl_x >= dr_x) ? (dl_x - dr_x) : (dr_x - dl_x);
      near = (dr_x > (dl_x + TH_X));
      occ  = s1_oob | near;
      mis  = !s1_oob && (diff > TH_X) && !near;
   end

   assign bus.dout_valid = dout_valid_q;
   assign bus.dout       = dout_q;
   assign bus.dout_eol   = dout_eol_q;

`ifdef LRC_STATS_EN
   localparam int SW = CWIDTH + 10;

   logic          s1_sof;
   logic [SW-1:0] occ_live, mis_live;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_sof      <= 1'b0;
         occ_live    <= '0;
         mis_live    <= '0;
         occ_cnt     <= '0;
         mis_cnt     <= '0;
         stats_valid <= 1'b0;
      end else if (clken) begin
         if (bus.din_valid) begin
            s1_sof <= bus.sof;
         end
         stats_valid <= 1'b0;
         if (s1_vld) begin
            if (s1_sof) begin
               occ_cnt     <= occ_live;
               mis_cnt     <= mis_live;
               stats_valid <= 1'b1;
               occ_live    <= SW'(occ);
               mis_live    <= SW'(mis);
            end else begin
               if (occ && !(&occ_live)) occ_live <= occ_live + SW'(1);
               if (mis && !(&mis_live)) mis_live <= mis_live + SW'(1);
            end
         end
      end
   end
`endif
endmodule
